// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_pkg: state codes, datapath select encodings, opcode/funct constants |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mc_ctrl_pkg;

  // ctrl_encode_def: sequencer states and datapath select encodings
  typedef enum logic [3:0] {
    ST_FETCH = 4'd0,
    ST_DCD   = 4'd1,
    ST_EXE   = 4'd2,
    ST_MA    = 4'd3,
    ST_MRD   = 4'd4,
    ST_MWB   = 4'd5,
    ST_MWR   = 4'd6,
    ST_AWB   = 4'd7,
    ST_BR    = 4'd8,
    ST_JMP   = 4'd9
  } state_e;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_RA = 2'b10;

  // instruction_def: opcode and funct constants
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  typedef enum logic [3:0] {
    CL_ILL  = 4'd0,
    CL_ADDU = 4'd1,
    CL_SUBU = 4'd2,
    CL_ORI  = 4'd3,
    CL_LUI  = 4'd4,
    CL_LW   = 4'd5,
    CL_SW   = 4'd6,
    CL_BEQ  = 4'd7,
    CL_J    = 4'd8,
    CL_JAL  = 4'd9
  } iclass_e;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_dec: maps latched op/funct to an instruction class and EXE selects |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic       bsel,
  output logic [1:0] aluop,
  output logic [1:0] extop
);

  always_comb begin
    iclass = CL_ILL;
    bsel   = 1'b0;
    aluop  = ALU_ADD;
    extop  = EXT_ZERO;
    case (op)
      OP_RTYPE: begin
        if (funct == F_ADDU) begin
          iclass = CL_ADDU;
        end else if (funct == F_SUBU) begin
          iclass = CL_SUBU;
          aluop  = ALU_SUB;
        end
      end
      OP_ORI: begin
        iclass = CL_ORI;
        bsel   = 1'b1;
        aluop  = ALU_OR;
      end
      // lui relies on rs being $0, so OR with the shifted immediate is a move
      OP_LUI: begin
        iclass = CL_LUI;
        bsel   = 1'b1;
        aluop  = ALU_OR;
        extop  = EXT_LUI;
      end
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      OP_BEQ:  iclass = CL_BEQ;
      OP_J:    iclass = CL_J;
      OP_JAL:  iclass = CL_JAL;
      default: iclass = CL_ILL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl: multi-cycle MIPS control sequencer with DM ready handshake.       |
// | Optional MC_CTRL_PERF_CNT_EN adds cycle / retired-instruction counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       funct,
  input  logic             Zero,
  input  logic             mem_rdy,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             DMWr,
  output logic             DMRd,
  output logic [1:0]       NPCOp,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic             BSel,
  output logic [1:0]       WDSel,
  output logic [1:0]       GPRSel,
  output logic [3:0]       state,
  output logic             mem_err,
  output logic             ill_op
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int WCNT_W = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("mc_ctrl: CNT_W must be at least 1");
  end

  state_e            cur_st;
  state_e            nxt_st;
  logic [5:0]        op_q;
  logic [5:0]        funct_q;
  logic [WCNT_W-1:0] wcnt;
  logic              tmo_hit;
  logic              tmo_exit;
  iclass_e           iclass;
  logic              dec_bsel;
  logic [1:0]        dec_aluop;
  logic [1:0]        dec_extop;

  mc_ctrl_dec u_dec (
    .op     (op_q),
    .funct  (funct_q),
    .iclass (iclass),
    .bsel   (dec_bsel),
    .aluop  (dec_aluop),
    .extop  (dec_extop)
  );

  assign tmo_hit = (MEM_TMO != 0) && (wcnt == TMO_LAST);
  assign state   = cur_st;

  // All strobes are forced low while rst is held so an aborted access never writes
  always_comb begin
    nxt_st   = ST_FETCH;
    tmo_exit = 1'b0;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RFWr     = 1'b0;
    DMWr     = 1'b0;
    DMRd     = 1'b0;
    NPCOp    = NPC_PC4;
    ALUOp    = ALU_ADD;
    ExtOp    = EXT_ZERO;
    BSel     = 1'b0;
    WDSel    = WD_ALU;
    GPRSel   = GPR_RD;
    ill_op   = 1'b0;
    if (!rst) begin
      case (cur_st)
        ST_FETCH: begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          nxt_st = ST_DCD;
        end
        ST_DCD: begin
          case (iclass)
            CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: nxt_st = ST_EXE;
            CL_LW, CL_SW:                     nxt_st = ST_MA;
            CL_BEQ:                           nxt_st = ST_BR;
            CL_J, CL_JAL:                     nxt_st = ST_JMP;
            default:                          ill_op = 1'b1;
          endcase
        end
        ST_EXE: begin
          BSel   = dec_bsel;
          ALUOp  = dec_aluop;
          ExtOp  = dec_extop;
          nxt_st = ST_AWB;
        end
        ST_AWB: begin
          RFWr   = 1'b1;
          GPRSel = (iclass == CL_ADDU || iclass == CL_SUBU) ? GPR_RD : GPR_RT;
        end
        ST_MA: begin
          BSel   = 1'b1;
          ExtOp  = EXT_SIGN;
          nxt_st = (iclass == CL_LW) ? ST_MRD : ST_MWR;
        end
        ST_MRD: begin
          DMRd = 1'b1;
          if (mem_rdy)      nxt_st = ST_MWB;
          else if (tmo_hit) tmo_exit = 1'b1;
          else              nxt_st = ST_MRD;
        end
        ST_MWR: begin
          DMWr = 1'b1;
          if (mem_rdy)      nxt_st = ST_FETCH;
          else if (tmo_hit) tmo_exit = 1'b1;
          else              nxt_st = ST_MWR;
        end
        ST_MWB: begin
          RFWr   = 1'b1;
          WDSel  = WD_DM;
          GPRSel = GPR_RT;
        end
        ST_BR: begin
          ALUOp = ALU_SUB;
          ExtOp = EXT_SIGN;
          PCWr  = Zero;
          NPCOp = NPC_BR;
        end
        ST_JMP: begin
          PCWr  = 1'b1;
          NPCOp = NPC_JMP;
          if (iclass == CL_JAL) begin
            RFWr   = 1'b1;
            WDSel  = WD_PC4;
            GPRSel = GPR_RA;
          end
        end
        default: nxt_st = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st  <= ST_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if (IRWr) begin
        op_q    <= OpCode;
        funct_q <= funct;
      end
      // Counts consecutive wait cycles; clears on any exit from MRD/MWR
      if ((cur_st == ST_MRD || cur_st == ST_MWR) && nxt_st == cur_st) begin
        wcnt <= wcnt + 1'b1;
      end else begin
        wcnt <= '0;
      end
      if (tmo_exit) begin
        mem_err <= 1'b1;
      end
    end
  end

`ifdef MC_CTRL_PERF_CNT_EN
  logic retire;
  assign retire = (cur_st != ST_FETCH) && (nxt_st == ST_FETCH) && !ill_op && !tmo_exit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= '0;
      instret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (retire) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
